// File: rtl/mmio_timer.sv
// ============================================================================
// Module   : mmio_timer
// Brief    : Chip-select bus timer: wait-stated register access, 32-bit counter
//            with compare/auto-reload/IRQ. Optional prescaler: MMIO_TIMER_PRESCALE_EN
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_timer #(
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        ready,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [1:0] c_a_ctrl   = 2'd0;
   localparam logic [1:0] c_a_count  = 2'd1;
   localparam logic [1:0] c_a_cmp    = 2'd2;
   localparam logic [1:0] c_a_status = 2'd3;

   state_t      r_state, w_state_nxt;
   logic        w_latch, w_commit;
   logic [1:0]  r_addr;
   logic        r_wr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wcnt;
   logic        r_ready, r_irq;
   logic [31:0] r_data_out, w_rdata, w_ctrl_rd;
   logic        r_en, r_auto, r_irq_en;
   logic [31:0] r_count, r_cmp;
   logic        r_match, r_ovf;
   logic        w_tick, w_eq, w_set_match, w_set_ovf;
   logic        w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_status;
   logic        w_unused_addr;

   assign w_unused_addr = ^{addr[31:4], addr[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: if (cs) begin
            w_latch     = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!cs) begin
               w_state_nxt = S_IDLE;
            end else if (r_wcnt == 4'd0) begin
               w_commit    = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: if (!cs) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= 2'd0;
         r_wr    <= 1'b0;
         r_wdata <= 32'd0;
         r_wcnt  <= 4'd0;
      end else if (w_latch) begin
         r_addr  <= addr[3:2];
         r_wr    <= wr;
         r_wdata <= data_in;
         r_wcnt  <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT && cs && r_wcnt != 4'd0) begin
         r_wcnt  <= r_wcnt - 4'd1;
      end
   end

   assign w_wr_ctrl   = w_commit && r_wr && (r_addr == c_a_ctrl);
   assign w_wr_count  = w_commit && r_wr && (r_addr == c_a_count);
   assign w_wr_cmp    = w_commit && r_wr && (r_addr == c_a_cmp);
   assign w_wr_status = w_commit && r_wr && (r_addr == c_a_status);

`ifdef MMIO_TIMER_PRESCALE_EN
   logic [7:0] r_prescale, r_pcnt;

   assign w_tick    = r_en && (r_pcnt == r_prescale);
   assign w_ctrl_rd = {16'd0, r_prescale, 5'd0, r_irq_en, r_auto, r_en};

   // Phase restarts whenever the timer is stopped or COUNT is reloaded by software
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              r_pcnt <= 8'd0;
      else if (!r_en || w_wr_count || w_tick) r_pcnt <= 8'd0;
      else                                  r_pcnt <= r_pcnt + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_prescale <= 8'd0;
      else if (w_wr_ctrl) r_prescale <= r_wdata[15:8];
   end
`else
   assign w_tick    = r_en;
   assign w_ctrl_rd = {29'd0, r_irq_en, r_auto, r_en};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en     <= 1'b0;
         r_auto   <= 1'b0;
         r_irq_en <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en     <= r_wdata[0];
         r_auto   <= r_wdata[1];
         r_irq_en <= r_wdata[2];
      end
   end

   assign w_eq        = (r_count == r_cmp);
   assign w_set_match = w_tick && !w_wr_count && w_eq;
   assign w_set_ovf   = w_tick && !w_wr_count && !w_eq && (r_count == 32'hFFFF_FFFF);

   // A software COUNT write suppresses the tick entirely; all-ones wraps via +1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 32'd0;
      end else if (w_wr_count) begin
         r_count <= r_wdata;
      end else if (w_tick) begin
         if (w_eq && r_auto) r_count <= 32'd0;
         else                r_count <= r_count + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_cmp <= 32'hFFFF_FFFF;
      else if (w_wr_cmp) r_cmp <= r_wdata;
   end

   // Hardware set is OR-ed after the W1C mask so a coincident set wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_match <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_match <= (r_match & ~(w_wr_status & r_wdata[0])) | w_set_match;
         r_ovf   <= (r_ovf   & ~(w_wr_status & r_wdata[1])) | w_set_ovf;
      end
   end

   always_comb begin
      w_rdata = 32'd0;
      case (r_addr)
         c_a_ctrl:   w_rdata = w_ctrl_rd;
         c_a_count:  w_rdata = r_count;
         c_a_cmp:    w_rdata = r_cmp;
         c_a_status: w_rdata = {30'd0, r_ovf, r_match};
         default:    w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready    <= 1'b0;
         r_data_out <= 32'd0;
         r_irq      <= 1'b0;
      end else begin
         r_ready <= w_commit;
         r_irq   <= r_match & r_irq_en;
         if (w_commit && !r_wr) r_data_out <= w_rdata;
      end
   end

   assign ready    = r_ready;
   assign data_out = r_data_out;
   assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// ============================================================================
// Module   : tb_mmio_timer
// Brief    : Randomized bench for mmio_timer against a transaction-level model
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_timer;

   localparam int WS = 1;
`ifdef MMIO_TIMER_PRESCALE_EN
   localparam logic [31:0] c_ctrl_mask = 32'h0000_FF07;
`else
   localparam logic [31:0] c_ctrl_mask = 32'h0000_0007;
`endif

   logic        clk, rst, cs, wr, ready, irq;
   logic [31:0] addr, data_in, data_out;

   mmio_timer #(.WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst), .cs(cs), .wr(wr), .addr(addr),
      .data_in(data_in), .data_out(data_out), .ready(ready), .irq(irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int fails  = 0;
   int ecount = 0;
   always @(posedge clk) ecount <= ecount + 1;

   typedef struct {
      int          at;
      bit          w;
      bit [1:0]    a;
      logic [31:0] d;
   } op_t;
   op_t q[$];

   // Reference state: register contents plus expected pin values after each edge
   logic [31:0] m_ctrl, m_count, m_cmp, e_dout;
   logic        m_match, m_ovf, e_ready, e_irq;
   int          m_phase;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mrd(input bit [1:0] a);
      case (a)
         2'd0:    return m_ctrl;
         2'd1:    return m_count;
         2'd2:    return m_cmp;
         default: return {30'd0, m_ovf, m_match};
      endcase
   endfunction

   task automatic model_reset();
      m_ctrl = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_ovf = 0;
      m_phase = 0; e_dout = 0; e_ready = 0; e_irq = 0;
      q.delete();
   endtask

   // Advance the model across the coming rising edge using the inputs now applied
   task automatic model_step();
      bit  com, wcount, tick, set_m, set_o;
      op_t op;
      int  ps;
      com = 0;
      op  = '{0, 0, 2'd0, 32'd0};
      if (q.size() > 0 && q[0].at == ecount + 1) begin
         com = 1;
         op  = q.pop_front();
      end
      e_irq   = m_match & m_ctrl[2];
      e_ready = com;
      if (com && !op.w) e_dout = mrd(op.a);
      wcount = com && op.w && op.a == 2'd1;
      ps     = int'(m_ctrl[15:8]);
      tick   = m_ctrl[0] && (m_phase == ps);
      set_m  = 0;
      set_o  = 0;
      if (wcount) m_count = op.d;
      else if (tick) begin
         if (m_count == m_cmp) begin
            set_m   = 1;
            m_count = m_ctrl[1] ? 32'd0 : m_count + 1;
         end else if (m_count == 32'hFFFF_FFFF) begin
            set_o   = 1;
            m_count = 0;
         end else m_count = m_count + 1;
      end
      m_phase = (!m_ctrl[0] || wcount || tick) ? 0 : m_phase + 1;
      if (com && op.w && op.a == 2'd3) begin
         if (op.d[0]) m_match = 0;
         if (op.d[1]) m_ovf   = 0;
      end
      m_match = m_match | set_m;
      m_ovf   = m_ovf | set_o;
      if (com && op.w && op.a == 2'd0) m_ctrl = op.d & c_ctrl_mask;
      if (com && op.w && op.a == 2'd2) m_cmp  = op.d;
   endtask

   initial begin : compare_proc
      model_reset();
      forever begin
         @(negedge clk);
         if (rst) model_reset();
         chk("ready", {31'd0, ready}, {31'd0, e_ready});
         chk("data_out", data_out, e_dout);
         chk("irq", {31'd0, irq}, {31'd0, e_irq});
         if (!rst) model_step();
      end
   end

   task automatic drive_start(input bit w, input bit [1:0] a, input logic [31:0] d);
      logic [31:0] r;
      r       = $urandom();
      cs      = 1'b1;
      wr      = w;
      addr    = {r[31:4], a, r[1:0]};
      data_in = d;
   endtask

   // cs is already high; k is the edge that latches the access
   task automatic finish(input int k, input bit w, input bit [1:0] a, input logic [31:0] d,
                         input int hold, output logic [31:0] rd);
      q.push_back('{k + 1 + WS, w, a, d});
      while (ecount < k + 1 + WS) @(posedge clk);
      @(negedge clk);
      rd = data_out;
      repeat (hold + 1) @(posedge clk);
      #2;
      cs      = 1'b0;
      data_in = $urandom();
   endtask

   task automatic access(input bit w, input bit [1:0] a, input logic [31:0] d,
                         input bit abort, input int hold, output logic [31:0] rd);
      int k;
      @(posedge clk);
      #2;
      drive_start(w, a, d);
      k  = ecount + 1;
      rd = 32'd0;
      if (abort) begin
         repeat ($urandom_range(1, WS + 1)) @(posedge clk);
         #2;
         cs = 1'b0;
      end else begin
         finish(k, w, a, d, hold, rd);
      end
   endtask

   task automatic wr_reg(input bit [1:0] a, input logic [31:0] d);
      logic [31:0] rd;
      access(1, a, d, 0, 0, rd);
   endtask

   task automatic rd_reg(input bit [1:0] a, output logic [31:0] rd);
      access(0, a, 32'd0, 0, 0, rd);
   endtask

   logic [31:0] c_reset_vals [4];
   logic [31:0] rd, d;
   bit   [1:0]  a;
   int          k;

   initial begin : main
      c_reset_vals = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
      rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = 32'd0; data_in = 32'd0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         rd_reg(2'(i), rd);
         chk("reset_read", rd, c_reset_vals[i]);
      end

      wr_reg(2'd2, 32'd5);
      wr_reg(2'd0, 32'h7);
      repeat (20) @(posedge clk);
      rd_reg(2'd3, rd);
      chk("match_set", rd & 32'h1, 32'h1);
      @(negedge clk);
      chk("irq_on", {31'd0, irq}, 32'd1);
      rd_reg(2'd1, rd);
      chk("count_reload_range", {31'd0, rd <= 32'd5}, 32'd1);

      wr_reg(2'd0, 32'h0);
      wr_reg(2'd2, 32'd100);
      wr_reg(2'd3, 32'h3);
      wr_reg(2'd1, 32'hFFFF_FFFE);
      wr_reg(2'd0, 32'h1);
      repeat (3) @(posedge clk);
      wr_reg(2'd0, 32'h0);
      rd_reg(2'd3, rd);
      chk("ovf_status", rd, 32'h2);
      wr_reg(2'd3, 32'h2);
      rd_reg(2'd3, rd);
      chk("ovf_cleared", rd, 32'h0);

      access(1, 2'd2, 32'd77, 1, 0, rd);
      rd_reg(2'd2, rd);
      chk("abort_no_commit", rd, 32'd100);
      access(1, 2'd2, 32'd3, 0, 6, rd);

      wr_reg(2'd1, 32'd0);
      wr_reg(2'd0, 32'h3);
      for (int g = 0; g < 8; g++) begin
         access(1, 2'd3, 32'h1, 0, g % 2, rd);
         repeat (g % 3) @(posedge clk);
      end
      wr_reg(2'd0, 32'h0);

      wr_reg(2'd1, 32'd0);
      wr_reg(2'd0, 32'h0301);
      repeat (13) @(posedge clk);
      rd_reg(2'd0, rd);
      chk("ctrl_prescale_rd", rd, 32'h0301 & c_ctrl_mask);
      wr_reg(2'd0, 32'h0);

      for (int n = 0; n < 300; n++) begin
         a = 2'($urandom_range(0, 3));
         d = $urandom();
         case (a)
            2'd0: d[15:10] = 6'd0;
            2'd1: d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : m_cmp - 32'($urandom_range(0, 6));
            2'd2: if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 20));
            default: ;
         endcase
         access(1'($urandom_range(0, 1)), a, d, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3), rd);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      // Reset in the middle of a write, cs left high across the reset
      @(posedge clk);
      #2;
      drive_start(1, 2'd0, 32'h5);
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      k = ecount + 1;
      finish(k, 1, 2'd0, 32'h5, 0, rd);
      rd_reg(2'd0, rd);
      chk("ctrl_after_restart", rd, 32'h5);
      rd_reg(2'd2, rd);
      chk("cmp_after_reset", rd, 32'hFFFF_FFFF);

      repeat (3) @(posedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that responds to bus accesses selected by the system address decoder's chip-select. It sits on the data-memory bus beside data RAM. It latches each access while `CS` is high, inserts programmable wait states, commits writes or returns read data with a one-cycle `READY` pulse, and runs a 32-bit up-counter with compare match, auto-reload and an interrupt output.

## Interface
- `WAIT_STATES`, default 1: extra cycles between latching an access and completing it (0–15).
- `CLK`  in  1: clock, all state updates on the rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `CS`  in  1: chip select from the address decoder; high for the whole access.
- `WR`  in  1: 1 = write, 0 = read; sampled with `CS`.
- `ADDR`  in  32: byte address; only `ADDR[3:2]` is used (0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS); `ADDR[1:0]` and `ADDR[31:4]` are ignored.
- `DATA_IN`  in  32: write data; sampled with `CS`.
- `DATA_OUT`  out  32: read data; valid while `READY` is high and held until the next read completes.
- `READY`  out  1: one-cycle completion pulse.
- `IRQ`  out  1: `STATUS[0] & CTRL[2]`.

## Operation
- Registers:
  - CTRL: bit 0 EN, bit 1 AUTO_RELOAD, bit 2 IRQ_EN, bits [15:8] PRESCALE (see Configuration); other bits read 0.
  - COUNT: 32-bit count value.
  - COMPARE: 32-bit compare value.
  - STATUS: bit 0 MATCH (sticky), bit 1 OVF (sticky); other bits read 0. Writes are write-1-to-clear per bit.
- Access FSM:
  - IDLE: `CS`=1 latches `ADDR[3:2]`, `WR` and `DATA_IN`, loads the wait counter with `WAIT_STATES`, and moves to WAIT.
  - WAIT: if `CS`=0, abort to IDLE with no commit and no `READY`. Otherwise, if the wait counter ≠ 0, decrement it. If it = 0, commit the write or capture read data into `DATA_OUT`, set `READY`=1, and move to HOLD.
  - HOLD: `READY`=0. Stay until `CS`=0, then go to IDLE. A continuously high `CS` never produces a second access.
- Counter, evaluated on each tick while EN=1:
  - If COUNT == COMPARE: set MATCH. With AUTO_RELOAD=1, COUNT becomes 0; otherwise COUNT increments.
  - Else if COUNT == 32'hFFFFFFFF: COUNT wraps to 0 and OVF is set.
  - Else: COUNT increments.
- Simultaneous events:
  - A bus write to COUNT overrides a tick in the same cycle.
  - A write to COMPARE takes effect on the next tick.
  - When a STATUS W1C coincides with a hardware set of the same bit, the set wins.
  - A read of COUNT returns the pre-tick value at the commit edge.
- EN=0 freezes COUNT. MATCH and OVF keep their values.

## Timing
- Reset values:
  - FSM = IDLE.
  - `READY`=0, `DATA_OUT`=0, `IRQ`=0.
  - CTRL=0, COUNT=0, COMPARE=32'hFFFFFFFF, STATUS=0.
  - Prescale counter = 0.
- If `CS` is sampled high in IDLE at edge k, `READY` rises after edge k+1+`WAIT_STATES` and falls after the following edge.
- A write becomes visible in the register at the same edge that `READY` rises.
- `IRQ` updates one cycle after the MATCH or CTRL change that causes it.
- `RST` asserted mid-access: abort immediately with no commit. After `RST` is released, an access with `CS` still high restarts from IDLE.

## Configuration
- `MMIO_TIMER_PRESCALE_EN` defined:
  - CTRL[15:8] is read/write.
  - An internal 8-bit prescale counter produces one tick every CTRL[15:8]+1 cycles while EN=1.
  - The prescale counter clears when EN=0 or when COUNT is written.
- Not defined:
  - A tick occurs every cycle while EN=1.
  - CTRL[15:8] ignores writes and reads 0.

## Test plan
- Reset, then read all four registers (`WAIT_STATES`=1) → `READY` after 3 edges per access; data 0, 0, 32'hFFFFFFFF, 0.
- Write COMPARE=5, write CTRL=32'h7 → MATCH set and `IRQ`=1 one cycle after COUNT reaches 5. COUNT then reads 0, 1, … (auto-reload).
- Write COUNT=32'hFFFFFFFE, CTRL=1 → after 2 ticks COUNT=0 and STATUS=2. Writing STATUS=2 returns STATUS to 0.
- Start a write, drop `CS` during WAIT → no `READY`, register unchanged. Hold `CS` high after `READY` → exactly one `READY` pulse.
- Write STATUS=1 in the same cycle a match occurs → MATCH remains 1.
- With `MMIO_TIMER_PRESCALE_EN` and CTRL=32'h0301 → COUNT increments once every 4 cycles. Without the macro, the same write → CTRL reads 1 and COUNT increments every cycle.
